// File: rtl/cryptkey_bus_pkg.sv
// rtl/cryptkey_bus_pkg.sv - shared bus guard types and constants
package cryptkey_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'h0,
    ST_REQ  = 2'h1,
    ST_RESP = 2'h2
  } guard_state_e;

  // All-zero word decodes as an illegal instruction on RV32, so a hung fetch traps.
  localparam logic [31:0] ILLEGAL_INSTRUCTION = 32'h0000_0000;

  localparam int DEFAULT_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/mem_bus_guard.sv
// rtl/mem_bus_guard.sv - registered request/response guard with timeout termination and logging
module mem_bus_guard
  import cryptkey_bus_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int          CNT_WIDTH      = 8,
  parameter logic [31:0] TIMEOUT_RDATA  = ILLEGAL_INSTRUCTION
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_valid,
  input  logic        cpu_instr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wstrb,
  output logic        cpu_ready,
  output logic [31:0] cpu_rdata,
  output logic        tgt_valid,
  output logic        tgt_instr,
  output logic [31:0] tgt_addr,
  output logic [31:0] tgt_wdata,
  output logic [3:0]  tgt_wstrb,
  input  logic        tgt_ready,
  input  logic [31:0] tgt_rdata,
  output logic        tgt_abort,
  input  logic        err_clear,
  output logic [7:0]  err_count,
  output logic [31:0] err_addr
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  guard_state_e         state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 tgt_valid_q, tgt_valid_d;
  logic                 tgt_instr_q, tgt_instr_d;
  logic [31:0]          tgt_addr_q, tgt_addr_d;
  logic [31:0]          tgt_wdata_q, tgt_wdata_d;
  logic [3:0]           tgt_wstrb_q, tgt_wstrb_d;
  logic                 cpu_ready_q, cpu_ready_d;
  logic [31:0]          cpu_rdata_q, cpu_rdata_d;
  logic                 tgt_abort_q, tgt_abort_d;
  logic [7:0]           err_count_q, err_count_d;
  logic [31:0]          err_addr_q, err_addr_d;
  logic                 timeout_hit;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tgt_valid_d = 1'b0;
    tgt_instr_d = tgt_instr_q;
    tgt_addr_d  = tgt_addr_q;
    tgt_wdata_d = tgt_wdata_q;
    tgt_wstrb_d = tgt_wstrb_q;
    cpu_ready_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    tgt_abort_d = 1'b0;
    timeout_hit = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cpu_valid) begin
          tgt_instr_d = cpu_instr;
          tgt_addr_d  = cpu_addr;
          tgt_wdata_d = cpu_wdata;
          tgt_wstrb_d = cpu_wstrb;
          cnt_d       = '0;
          tgt_valid_d = 1'b1;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        // A core answering in the last allowed cycle beats the timeout.
        if (tgt_ready) begin
          cpu_rdata_d = tgt_rdata;
          cpu_ready_d = 1'b1;
          state_d     = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          cpu_rdata_d = TIMEOUT_RDATA;
          cpu_ready_d = 1'b1;
          tgt_abort_d = 1'b1;
          timeout_hit = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d       = cnt_q + 1'b1;
          tgt_valid_d = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    err_count_d = err_count_q;
    err_addr_d  = err_addr_q;
    if (timeout_hit) begin
      err_addr_d = tgt_addr_q;
      if (err_clear) begin
        err_count_d = 8'h01;
      end else if (err_count_q != 8'hff) begin
        err_count_d = err_count_q + 8'h01;
      end
    end else if (err_clear) begin
      err_count_d = 8'h00;
      err_addr_d  = 32'h0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      tgt_valid_q <= 1'b0;
      tgt_instr_q <= 1'b0;
      tgt_addr_q  <= 32'h0;
      tgt_wdata_q <= 32'h0;
      tgt_wstrb_q <= 4'h0;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= 32'h0;
      tgt_abort_q <= 1'b0;
      err_count_q <= 8'h00;
      err_addr_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tgt_valid_q <= tgt_valid_d;
      tgt_instr_q <= tgt_instr_d;
      tgt_addr_q  <= tgt_addr_d;
      tgt_wdata_q <= tgt_wdata_d;
      tgt_wstrb_q <= tgt_wstrb_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      tgt_abort_q <= tgt_abort_d;
      err_count_q <= err_count_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign cpu_ready = cpu_ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign tgt_valid = tgt_valid_q;
  assign tgt_instr = tgt_instr_q;
  assign tgt_addr  = tgt_addr_q;
  assign tgt_wdata = tgt_wdata_q;
  assign tgt_wstrb = tgt_wstrb_q;
  assign tgt_abort = tgt_abort_q;
  assign err_count = err_count_q;
  assign err_addr  = err_addr_q;

endmodule
